// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: keeps one imem request in flight, feeds the IF/ID
// payload register, parks a late response in a hold buffer under stall, and flushes on redirect.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_instr_o,
   output logic        if_valid_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_instr_q, hold_instr_d;

   logic [31:0] redirect_tgt;
   logic [31:0] pc_inc;
   logic        xfer_done;

   // Acks are only meaningful while our own request is on the bus.
   assign xfer_done    = req_q & imem_ack_i;
   assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};
   assign pc_inc       = pc_q + 32'd4;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      req_d        = req_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      if_valid_d   = if_valid_q;
      fetch_cnt_d  = fetch_cnt_q;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;

      // A free-running ID with nothing new to take sees a bubble.
      if (!stall_i) begin
         if_valid_d = 1'b0;
      end

      if (redirect_i) begin
         pc_d         = redirect_tgt;
         if_valid_d   = 1'b0;
         hold_pc_d    = 32'h0;
         hold_instr_d = 32'h0;
         req_d        = 1'b1;
         // An unanswered request must still drain on its old address.
         if ((state_q == FETCH || state_q == DISCARD) && !xfer_done) begin
            state_d = DISCARD;
         end else begin
            state_d = FETCH;
            addr_d  = redirect_tgt;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
            FETCH: begin
               if (xfer_done) begin
                  pc_d   = pc_inc;
                  addr_d = pc_inc;
                  if (!stall_i || !if_valid_q) begin
                     if_pc_d     = pc_q;
                     if_instr_d  = imem_rdata_i;
                     if_valid_d  = 1'b1;
                     fetch_cnt_d = fetch_cnt_q + 32'd1;
                  end else begin
                     hold_pc_d    = pc_q;
                     hold_instr_d = imem_rdata_i;
                     req_d        = 1'b0;
                     state_d      = HOLD;
                  end
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  if_pc_d     = hold_pc_q;
                  if_instr_d  = hold_instr_q;
                  if_valid_d  = 1'b1;
                  fetch_cnt_d = fetch_cnt_q + 32'd1;
                  req_d       = 1'b1;
                  addr_d      = pc_q;
                  state_d     = FETCH;
               end
            end
            DISCARD: begin
               if (xfer_done) begin
                  req_d   = 1'b1;
                  addr_d  = pc_q;
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         if_pc_q      <= 32'h0;
         if_instr_q   <= 32'h0;
         if_valid_q   <= 1'b0;
         fetch_cnt_q  <= 32'h0;
         hold_pc_q    <= 32'h0;
         hold_instr_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         if_valid_q   <= if_valid_d;
         fetch_cnt_q  <= fetch_cnt_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign if_pc_o     = if_pc_q;
   assign if_instr_o  = if_instr_q;
   assign if_valid_o  = if_valid_q;
   assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a small memory responder returns addr ^ KEY after a
// programmable delay; each step checks outputs on the falling edge.
module tb_fetch_ctrl;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic        if_valid_o;
   logic [31:0] fetch_cnt_o;

   int vectors     = 0;
   int miscompares = 0;

   int          ack_delay = 0;
   bit          resp_auto = 1'b1;
   int          wait_cnt  = 0;
   logic        man_ack   = 1'b0;
   logic [31:0] man_rdata = 32'h0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .stall_i       (stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_pc_o       (if_pc_o),
      .if_instr_o    (if_instr_o),
      .if_valid_o    (if_valid_o),
      .fetch_cnt_o   (fetch_cnt_o)
   );

   // Memory responder: acks after ack_delay idle cycles of an asserted request.
   initial begin : responder
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         if (resp_auto) begin
            if (imem_ack_i) wait_cnt = 0;
            if (!imem_req_o || !rst) begin
               imem_ack_i = 1'b0;
               wait_cnt   = 0;
            end else if (wait_cnt >= ack_delay) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = imem_addr_o ^ KEY;
            end else begin
               imem_ack_i = 1'b0;
               wait_cnt++;
            end
         end else begin
            imem_ack_i   = man_ack;
            imem_rdata_i = man_rdata;
            wait_cnt     = 0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s observed=%h", vectors, tag, obs);
   endtask

   task automatic check_deliver(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
      check({tag, "_pc"}, if_pc_o, pc);
      check({tag, "_instr"}, if_instr_o, pc ^ KEY);
      check({tag, "_valid"}, {31'h0, if_valid_o}, 32'd1);
      check({tag, "_cnt"}, fetch_cnt_o, cnt);
   endtask

   task automatic check_bubble(input string tag, input logic [31:0] addr, input logic [31:0] cnt);
      check({tag, "_valid"}, {31'h0, if_valid_o}, 32'd0);
      check({tag, "_addr"}, imem_addr_o, addr);
      check({tag, "_cnt"}, fetch_cnt_o, cnt);
   endtask

   task automatic do_reset(input int dly);
      rst        = 1'b0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      resp_auto  = 1'b1;
      ack_delay  = dly;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin : stim
      rst           = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      stall_i       = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_req", {31'h0, imem_req_o}, 32'd0);
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_if_pc", if_pc_o, 32'h0);
      check("rst_if_instr", if_instr_o, 32'h0);
      check("rst_valid", {31'h0, if_valid_o}, 32'd0);
      check("rst_cnt", fetch_cnt_o, 32'h0);

      // Zero-latency memory: one instruction per cycle after a single IDLE cycle
      rst = 1'b1;
      tick();
      check("idle_exit_req", {31'h0, imem_req_o}, 32'd1);
      check("idle_exit_addr", imem_addr_o, 32'h0);
      check("idle_exit_valid", {31'h0, if_valid_o}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_deliver($sformatf("b2b_%0d", i), 32'(4 * i), 32'(i + 1));
         check($sformatf("b2b_%0d_addr", i), imem_addr_o, 32'(4 * i + 4));
      end

      // Three-cycle ack delay: address held four cycles, bubbles in between
      ack_delay = 3;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 3; j++) begin
            tick();
            check_bubble($sformatf("dly_%0d_%0d", k, j), 32'(24 + 4 * k), 32'(6 + k));
         end
         tick();
         check_deliver($sformatf("dly_%0d_del", k), 32'(24 + 4 * k), 32'(7 + k));
      end

      // Stall with payload at 8: request for 12 parks in HOLD
      do_reset(0);
      tick();
      tick();
      tick();
      tick();
      check_deliver("stl_pre", 32'h8, 32'd3);
      stall_i = 1'b1;
      for (int s = 0; s < 5; s++) begin
         tick();
         check_deliver($sformatf("stl_frz_%0d", s), 32'h8, 32'd3);
         check($sformatf("stl_frz_%0d_req", s), {31'h0, imem_req_o}, 32'd0);
      end
      stall_i = 1'b0;
      tick();
      check_deliver("stl_rel", 32'hC, 32'd4);
      check("stl_rel_req", {31'h0, imem_req_o}, 32'd1);
      check("stl_rel_addr", imem_addr_o, 32'h10);
      tick();
      check_deliver("stl_next", 32'h10, 32'd5);

      // Redirect to 0x103 while the 0x20 request waits on a two-cycle ack
      do_reset(0);
      tick();
      for (int i = 0; i < 8; i++) tick();
      check_deliver("rdr_pre", 32'h1C, 32'd8);
      ack_delay = 2;
      tick();
      check_bubble("rdr_wait", 32'h20, 32'd8);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h103;
      tick();
      redirect_i = 1'b0;
      check_bubble("rdr_disc", 32'h20, 32'd8);
      check("rdr_disc_req", {31'h0, imem_req_o}, 32'd1);
      tick();
      check_bubble("rdr_drop", 32'h100, 32'd8);
      check("rdr_no_0x20", {31'h0, (if_valid_o && if_pc_o == 32'h20)}, 32'd0);
      tick();
      check_bubble("rdr_new_w0", 32'h100, 32'd8);
      tick();
      check_bubble("rdr_new_w1", 32'h100, 32'd8);
      tick();
      check_deliver("rdr_tgt", 32'h100, 32'd9);

      // Redirect together with stall while valid, target at the top of memory
      do_reset(0);
      tick();
      tick();
      tick();
      check_deliver("rs_pre", 32'h4, 32'd2);
      stall_i       = 1'b1;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      check_bubble("rs_flush", 32'hFFFF_FFFC, 32'd2);
      tick();
      check_deliver("rs_top", 32'hFFFF_FFFC, 32'd3);
      check("rs_wrap_addr", imem_addr_o, 32'h0);
      tick();
      check_deliver("rs_wrap", 32'h0, 32'd4);

      // Reset during a pending request; a stale ack after release is ignored
      do_reset(3);
      tick();
      check("rr_req", {31'h0, imem_req_o}, 32'd1);
      tick();
      check("rr_pend_valid", {31'h0, if_valid_o}, 32'd0);
      rst       = 1'b0;
      resp_auto = 1'b0;
      man_ack   = 1'b0;
      #1;
      check("rr_async_req", {31'h0, imem_req_o}, 32'd0);
      check("rr_async_addr", imem_addr_o, 32'h0);
      tick();
      rst       = 1'b1;
      man_ack   = 1'b1;
      man_rdata = 32'hDEAD_BEEF;
      tick();
      check_bubble("rr_stale", 32'h0, 32'd0);
      check("rr_stale_req", {31'h0, imem_req_o}, 32'd1);
      man_ack = 1'b0;
      tick();
      check_bubble("rr_gap", 32'h0, 32'd0);
      man_ack   = 1'b1;
      man_rdata = 32'h0 ^ KEY;
      tick();
      check_deliver("rr_first", 32'h0, 32'd1);
      man_ack = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
